// File: rtl/acc_pkg.sv
// Shared FSM encoding and default widths for the stream feeder.
package acc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 20;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/acc_stream_feeder_if.sv
// Memory read bus and accelerator input stream of the feeder.
interface acc_stream_feeder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              stall_i;
  logic              bus_free;

  modport master (
    output mem_rd_en, mem_addr, data_i, valid_i, bus_free,
    input  mem_rdata, stall_i
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_i, valid_i, bus_free,
    output mem_rdata, stall_i
  );

endinterface

// File: rtl/acc_out_capture.sv
// Counts and sums accelerator output words; clear beats a same-cycle capture.
module acc_out_capture #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_valid_o,
  output logic [31:0]       out_count,
  output logic [DATA_W-1:0] out_sum
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
      out_sum   <= '0;
    end else if (clr) begin
      out_count <= '0;
      out_sum   <= '0;
    end else if (acc_valid_o) begin
      out_count <= out_count + 32'd1;
      out_sum   <= out_sum + acc_data_o;
    end
  end

endmodule

// File: rtl/acc_stream_feeder.sv
// Block reader feeding the accelerator with gap and stall control.
// Output capture counters are built only with FEEDER_CAPTURE_EN.
module acc_stream_feeder
  import acc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [GAP_W-1:0]  gap,
  acc_stream_feeder_if.master bus,
  input  logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_valid_o,
  output logic [31:0]       out_count,
  output logic [DATA_W-1:0] out_sum,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, len_q, cnt_q;
  logic [GAP_W-1:0]  gap_q, gcnt_q;
  logic [DATA_W-1:0] data_q;
  logic              accept, last;
  logic              rd_en, valid, bfree;

  assign accept = start && (state_q == IDLE);
  assign last   = (cnt_q + ADDR_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start)
          state_d = (length == '0) ? DONE : ISSUE;
      ISSUE:
        if (!bus.stall_i) state_d = WAIT;
      WAIT:
        state_d = PRESENT;
      PRESENT:
        if (last)             state_d = DONE;
        else if (gap_q == '0) state_d = ISSUE;
        else                  state_d = GAP;
      GAP:
        if (gcnt_q == GAP_W'(1)) state_d = ISSUE;
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    valid = 1'b0;
    bfree = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      IDLE:    bfree = 1'b1;
      ISSUE: begin
        busy  = 1'b1;
        rd_en = !bus.stall_i;
        bfree = bus.stall_i;
      end
      WAIT:    busy = 1'b1;
      PRESENT: begin
        busy  = 1'b1;
        valid = 1'b1;
      end
      GAP: begin
        busy  = 1'b1;
        bfree = 1'b1;
      end
      DONE: begin
        done  = 1'b1;
        bfree = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and word count advance as each word is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
      gcnt_q <= '0;
      data_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= base_addr;
        len_q  <= length;
        gap_q  <= gap;
        cnt_q  <= '0;
      end
      if (state_q == WAIT)
        data_q <= bus.mem_rdata;
      if (state_q == PRESENT) begin
        cnt_q  <= cnt_q + ADDR_W'(1);
        addr_q <= addr_q + ADDR_W'(1);
        gcnt_q <= gap_q;
      end
      if (state_q == GAP)
        gcnt_q <= gcnt_q - GAP_W'(1);
    end
  end

  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = addr_q;
  assign bus.data_i    = data_q;
  assign bus.valid_i   = valid;
  assign bus.bus_free  = bfree;

`ifdef FEEDER_CAPTURE_EN
  acc_out_capture #(
    .DATA_W(DATA_W)
  ) u_cap (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .acc_data_o (acc_data_o),
    .acc_valid_o(acc_valid_o),
    .out_count  (out_count),
    .out_sum    (out_sum)
  );
`else
  logic unused_cap;
  assign unused_cap = ^{acc_data_o, acc_valid_o};
  assign out_count  = '0;
  assign out_sum    = '0;
`endif

endmodule

// File: tb/tb_acc_stream_feeder.sv
// Random/directed bench for acc_stream_feeder against a cycle timeline model.
// Capture expectations follow FEEDER_CAPTURE_EN.
module tb_acc_stream_feeder;

  localparam int DW   = 32;
  localparam int AW   = 20;
  localparam int GW   = 4;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic [GW-1:0] gap = '0;
  logic [DW-1:0] acc_data_o = '0;
  logic          acc_valid_o = 1'b0;
  logic [31:0]   out_count;
  logic [DW-1:0] out_sum;
  logic          busy, done;

  acc_stream_feeder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  acc_stream_feeder #(
    .DATA_W(DW), .ADDR_W(AW), .GAP_W(GW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .gap        (gap),
    .bus        (bus),
    .acc_data_o (acc_data_o),
    .acc_valid_o(acc_valid_o),
    .out_count  (out_count),
    .out_sum    (out_sum),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] salt = '0;

  always @(posedge clk)
    if (!rst_n)             bus.mem_rdata <= '0;
    else if (bus.mem_rd_en) bus.mem_rdata <= salt ^ DW'(bus.mem_addr);

  int            n_vec = 0;
  int            n_bad = 0;
  logic [31:0]   m_cnt = '0;
  logic [DW-1:0] m_sum = '0;
  logic [DW-1:0] exp_data = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.valid_i, bus.mem_rd_en, bus.bus_free, busy, done};
  endfunction

  function automatic logic [31:0] e_cnt();
`ifdef FEEDER_CAPTURE_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [DW-1:0] e_sum();
`ifdef FEEDER_CAPTURE_EN
    return m_sum;
`else
    return '0;
`endif
  endfunction

  task automatic drive_acc();
    acc_valid_o = ($urandom_range(0, 2) == 0);
    acc_data_o  = $urandom;
  endtask

  task automatic chk_cap();
    chk("out_count", out_count, e_cnt());
    chk("out_sum", out_sum, e_sum());
  endtask

  task automatic cap_step(input bit clr);
    if (clr) begin
      m_cnt = '0;
      m_sum = '0;
    end else if (acc_valid_o) begin
      m_cnt = m_cnt + 32'd1;
      m_sum = m_sum + acc_data_o;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.stall_i = 1'($urandom);
      drive_acc();
      #1;
      chk("idle_flags", flags(), 5'b00100);
      chk("idle_data", bus.data_i, exp_data);
      chk_cap();
      cap_step(1'b0);
    end
  endtask

  // mode: 0 no stall, 1 random stall, 2 six stall cycles before word 2
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l,
                          input logic [GW-1:0] g, input logic [DW-1:0] s,
                          input int mode, input bit restart);
    logic [4:0]    ef[MAXC];
    logic [AW-1:0] ea[MAXC];
    logic [DW-1:0] ed[MAXC];
    bit            sp[MAXC];
    int            t;
    for (int c = 0; c < MAXC; c++) begin
      ef[c] = '0;
      ea[c] = '0;
      ed[c] = '0;
      sp[c] = (mode == 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    t = 1;
    for (int k = 0; k < int'(l); k++) begin
      if (mode == 2 && k == 2) begin
        for (int i = 0; i < 6; i++) sp[t+i] = 1'b1;
        sp[t+6] = 1'b0;
      end
      while (sp[t]) begin
        ef[t] = 5'b00110;
        t++;
      end
      ef[t] = 5'b01010;
      ea[t] = AW'(b + AW'(k));
      t++;
      ef[t] = 5'b00010;
      t++;
      ef[t] = 5'b10010;
      ed[t] = s ^ DW'(AW'(b + AW'(k)));
      t++;
      if (k != int'(l) - 1)
        for (int i = 0; i < int'(g); i++) begin
          ef[t] = 5'b00110;
          t++;
        end
    end
    ef[t] = 5'b00101;

    @(negedge clk);
    salt        = s;
    start       = 1'b1;
    base_addr   = b;
    length      = l;
    gap         = g;
    bus.stall_i = 1'($urandom);
    drive_acc();
    #1;
    chk("start_flags", flags(), 5'b00100);
    chk_cap();
    cap_step(1'b1);

    for (int c = 1; c <= t; c++) begin
      @(negedge clk);
      start       = restart && (c == 2) && (l != '0);
      base_addr   = AW'($urandom);
      length      = AW'($urandom);
      gap         = GW'($urandom);
      bus.stall_i = sp[c];
      drive_acc();
      #1;
      chk("flags", flags(), ef[c]);
      if (ef[c][3]) chk("mem_addr", bus.mem_addr, ea[c]);
      if (ef[c][4]) exp_data = ed[c];
      chk("data_i", bus.data_i, exp_data);
      if (c == t) chk("done_addr", bus.mem_addr, AW'(b + l));
      chk_cap();
      cap_step(1'b0);
    end
    start = 1'b0;
  endtask

  initial begin
    bus.stall_i = 1'b0;
    #2;
    chk("rst_flags", flags(), 5'b00100);
    chk("rst_addr", bus.mem_addr, '0);
    chk("rst_data", bus.data_i, '0);
    chk("rst_cnt", out_count, 32'd0);
    chk("rst_sum", out_sum, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    idle_cycles(2);
    run_xfer(20'h0, 20'd4, 4'd0, 32'h0, 0, 1'b0);
    run_xfer(AW'($urandom), 20'd3, 4'd2, $urandom, 0, 1'b0);
    run_xfer(AW'($urandom), 20'd5, 4'd1, $urandom, 2, 1'b0);
    run_xfer(AW'($urandom), 20'd0, 4'd3, $urandom, 1, 1'b0);
    run_xfer(20'hFFFFE, 20'd3, 4'd0, $urandom, 0, 1'b0);
    run_xfer(AW'($urandom), 20'd6, 4'd1, $urandom, 0, 1'b1);

    // abort after two of ten words
    acc_valid_o = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      start       = (c == 0);
      base_addr   = AW'($urandom);
      length      = 20'd10;
      gap         = 4'd0;
      bus.stall_i = 1'b0;
      #1;
      if (c == 3 || c == 6) chk("pre_rst_valid", bus.valid_i, 1'b1);
      cap_step(c == 0);
    end
    @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt    = '0;
    m_sum    = '0;
    exp_data = '0;
    chk("abort_flags", flags(), 5'b00100);
    chk("abort_addr", bus.mem_addr, '0);
    chk("abort_data", bus.data_i, '0);
    chk_cap();
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("abort_hold", flags(), 5'b00100);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acc_valid_o = 1'b1;
      acc_data_o  = (i == 0) ? 32'h5 : (i == 1) ? 32'h7 : 32'hFFFFFFFF;
      #1;
      cap_step(1'b0);
    end
    @(negedge clk);
    acc_valid_o = 1'b0;
    #1;
`ifdef FEEDER_CAPTURE_EN
    chk("cap_count", out_count, 32'd3);
    chk("cap_sum", out_sum, 32'h0000000B);
`else
    chk("cap_count", out_count, 32'd0);
    chk("cap_sum", out_sum, 32'h0);
`endif
    cap_step(1'b0);

    run_xfer(AW'($urandom), 20'd4, 4'd0, $urandom, 0, 1'b0);
    repeat (30)
      run_xfer(AW'($urandom), AW'($urandom_range(0, 12)),
               GW'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 1), 1'($urandom));
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/acc_stream_feeder.md
Name: acc_stream_feeder

Overview:
- Synthesizable, parametrised stream source that reads a block of words from a word-addressed memory and presents them to the accelerator top on data_i/valid_i.
- Programmable inter-word gap, bus_free indication and weight-load stall.
- Replaces the fixed 1-in-3 testbench feeder in RTL_SIM, and is reused on-chip as the DMA-side feeder.
- Optional capture counter/checksum on the accelerator output stream.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 20, memory address width; also width of length and word counter.
- GAP_W, 4, width of programmable gap field.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address; latched on accepted start.
- length  in  ADDR_W  number of words; latched on accepted start.
- gap  in  GAP_W  extra idle cycles between words; latched on accepted start.
- stall_i  in  1  accelerator weight_ing; holds issue of the next read.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address, registered.
- mem_rdata  in  DATA_W  read data, valid in the cycle after mem_rd_en=1.
- data_i  out  DATA_W  word to accelerator, registered.
- valid_i  out  1  one-cycle qualifier for data_i.
- bus_free  out  1  feeder not using the memory bus.
- acc_data_o  in  DATA_W  accelerator output data.
- acc_valid_o  in  1  accelerator output qualifier.
- out_count  out  32  number of captured accelerator outputs.
- out_sum  out  DATA_W  running modulo-2^DATA_W sum of captured outputs.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse when the last word has been presented.

Behaviour:
- Reset values: state=IDLE, mem_addr=0, data_i=0, valid_i=0, busy=0, done=0, out_count=0, out_sum=0, word counter=0. Reset mid-transfer aborts immediately; no done pulse is issued.
- FSM states and transitions:
  - IDLE: on start, latch base/length/gap and load mem_addr=base_addr. If length=0, go to DONE; else go to ISSUE.
  - ISSUE: mem_rd_en = !stall_i (combinational from the state register and stall_i). If stall_i=1, stay in ISSUE. Else go to WAIT.
  - WAIT: capture mem_rdata into data_i at the end of the cycle; go to PRESENT.
  - PRESENT: valid_i=1 for exactly this cycle; word counter increments and mem_addr increments.
    - If this is the last word, go to DONE.
    - Else if gap=0, go to ISSUE.
    - Else load gap counter with gap and go to GAP.
  - GAP: decrement the gap counter; go to ISSUE when it reaches 1.
  - DONE: done=1 for one cycle; go to IDLE.
- Period per word: 3+gap cycles when unstalled. First valid_i occurs 3 cycles after the start-sample edge.
- busy=1 in ISSUE, WAIT, PRESENT and GAP.
- bus_free=1 in IDLE, GAP and DONE, and in ISSUE while stall_i=1. Otherwise 0.
- start while busy is ignored. Changes to base_addr, length or gap after start have no effect.
- Address wraps modulo 2^ADDR_W; base_addr+length overflow is legal and wraps to 0.
- stall_i is sampled only in ISSUE. Asserting it in WAIT or PRESENT does not cancel the word already in flight.
- data_i holds its last value when valid_i=0.

Optional Feature:
- Macro FEEDER_CAPTURE_EN.
- Defined: on every cycle with acc_valid_o=1 (in any state, including IDLE), out_count += 1 and out_sum += acc_data_o. Both counters clear on accepted start and on reset.
- Undefined: out_count and out_sum are constant 0; acc_data_o and acc_valid_o are ignored and no capture logic is synthesized.

Decomposition:
- Shared package acc_pkg: FSM state encoding (IDLE, ISSUE, WAIT, PRESENT, GAP, DONE) and default width constants DATA_W_DEF=32, ADDR_W_DEF=20.
- One natural sub-module: acc_out_capture, holding the out_count/out_sum logic. Instantiated only under FEEDER_CAPTURE_EN.

Test Plan:
- Basic transfer: base=0, length=4, gap=0, memory holds word i = i. Required: valid_i on 4 pulses exactly 3 cycles apart with data 0,1,2,3; done 1 cycle after the last pulse; mem_addr=4 at done.
- Gap and bus_free: length=3, gap=2. Required: valid_i period 5 cycles; bus_free=1 for the 2 GAP cycles each period.
- Stall: stall_i high for 6 cycles while in ISSUE before word 2. Required: mem_rd_en=0 and bus_free=1 throughout the stall; word 2 valid_i delayed by 6 cycles; data unchanged.
- Boundaries: length=0 gives done one cycle after start with no mem_rd_en. base=20'hFFFFE, length=3 gives addresses FFFFE, FFFFF, 00000. A second start while busy is ignored.
- Reset mid-transfer: rst_n low after 2 of 10 words. Required: all outputs at reset values asynchronously, no done pulse; a new start then runs cleanly.
- Capture (FEEDER_CAPTURE_EN): acc_valid_o pulsed 3 times with data 5, 7, FFFFFFFF. Required: out_count=3, out_sum=0000000B. With the macro undefined, both remain 0.
